// File: rtl/prog_mem_loadable.sv
// Loadable program memory: streaming valid/ready load port, registered fetch port.
// Per-word valid bits mask stale contents so unwritten words read as NOP.
module prog_mem_loadable #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 17,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              busy,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] prog_data,
  output logic              fetch_valid
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [IW-1:0]   LAST_W  = IW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] pd_q, pd_d;
  logic              fv_q, fv_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic          in_load;
  logic          xfer;
  logic          fin;
  logic          hit;
  logic [IW-1:0] ridx;

  assign in_load = (state_q == S_LOAD);
  assign xfer    = in_load & load_valid;
  assign fin     = xfer & (load_last | (wr_ptr_q == LAST_W));
  assign ridx    = address[IW-1:0];
  assign hit     = ({1'b0, address} < DEPTH_A) && valid_q[ridx];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    pd_d     = pd_q;
    fv_d     = 1'b0;
    unique case (1'b1)
      in_load: begin
        // A stalled fetch stage sees NOP while the program is rewritten
        pd_d = '0;
        if (xfer) begin
          valid_d[wr_ptr_q] = 1'b1;
          wr_ptr_d          = wr_ptr_q + 1'b1;
          cnt_d             = cnt_q + 1'b1;
        end
        if (fin) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (fetch_en) begin
          pd_d = hit ? mem_q[ridx] : '0;
          fv_d = 1'b1;
        end
        if (load_start) begin
          state_d  = S_LOAD;
          valid_d  = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      done_q   <= 1'b0;
      pd_q     <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      pd_q     <= pd_d;
      fv_q     <= fv_d;
    end
  end

  // Array has no reset; the valid bits hide whatever it holds
  always_ff @(posedge clk) begin
    if (xfer) mem_q[wr_ptr_q] <= load_data;
  end

  assign load_ready  = in_load;
  assign busy        = in_load;
  assign load_done   = done_q;
  assign load_count  = cnt_q;
  assign prog_data   = pd_q;
  assign fetch_valid = fv_q;

endmodule
